// File: rtl/hazard_pkg.sv
// Shared encodings for hazard detection and forwarding: register-destination select,
// write-back source select, controller FSM states and the destination-register helper.
package hazard_pkg;

    localparam logic [1:0] REGDST_RD = 2'd0;
    localparam logic [1:0] REGDST_RT = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;
    localparam logic [1:0] REGDST_K0 = 2'd3;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    function automatic logic [4:0] dest_reg(input logic [1:0] reg_dst,
                                            input logic [4:0] rd,
                                            input logic [4:0] rt);
        logic [4:0] d;
        case (reg_dst)
            REGDST_RD: d = rd;
            REGDST_RT: d = rt;
            REGDST_RA: d = 5'd31;
            default:   d = 5'd26;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_dest_match.sv
// Compares one pipeline stage's destination register against the ID-stage sources
// that are actually read; $0 and non-writing stages never match.
module hazard_dest_match
    import hazard_pkg::*;
(
    input  logic [4:0] stg_rd,
    input  logic [4:0] stg_rt,
    input  logic [1:0] stg_reg_dst,
    input  logic       stg_reg_wr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    output logic       hit_rs,
    output logic       hit_rt
);

    logic [4:0] dst;
    logic       wr_live;

    assign dst     = dest_reg(stg_reg_dst, stg_rd, stg_rt);
    assign wr_live = stg_reg_wr && (dst != 5'd0);
    assign hit_rs  = wr_live && id_use_rs && (dst == id_rs);
    assign hit_rt  = wr_live && id_use_rt && (dst == id_rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/interrupt-entry controller for the IF/ID and ID/EX registers. Stall
// outputs are Mealy in RUN so the first hazard cycle is held with no added latency.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_AheadBr,
    input  logic             ID_Redirect,
    input  logic [4:0]       EX_Rd,
    input  logic [4:0]       EX_Rt,
    input  logic [1:0]       EX_RegDst,
    input  logic [1:0]       EX_MemToReg,
    input  logic             EX_RegWr,
    input  logic [4:0]       MEM_Rd,
    input  logic [4:0]       MEM_Rt,
    input  logic [1:0]       MEM_RegDst,
    input  logic [1:0]       MEM_MemToReg,
    input  logic             MEM_RegWr,
    input  logic             IRQ,
    input  logic             IRQ_En,
    output logic             PC_Hold,
    output logic             IFID_Hold,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             IRQ_Take,
    output logic [CNT_W-1:0] StallCnt
);

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic ex_hit, mem_hit, ex_load, mem_load;
    logic [1:0] n_stall;
    logic stall, irq_take;

    state_t           state_q, state_d;
    logic             left_q, left_d;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_dest_match u_ex_match (
        .stg_rd(EX_Rd), .stg_rt(EX_Rt), .stg_reg_dst(EX_RegDst), .stg_reg_wr(EX_RegWr),
        .id_rs(ID_Rs), .id_rt(ID_Rt), .id_use_rs(ID_UseRs), .id_use_rt(ID_UseRt),
        .hit_rs(ex_hit_rs), .hit_rt(ex_hit_rt)
    );

    hazard_dest_match u_mem_match (
        .stg_rd(MEM_Rd), .stg_rt(MEM_Rt), .stg_reg_dst(MEM_RegDst), .stg_reg_wr(MEM_RegWr),
        .id_rs(ID_Rs), .id_rt(ID_Rt), .id_use_rs(ID_UseRs), .id_use_rt(ID_UseRt),
        .hit_rs(mem_hit_rs), .hit_rt(mem_hit_rt)
    );

    assign ex_hit   = ex_hit_rs || ex_hit_rt;
    assign mem_hit  = mem_hit_rs || mem_hit_rt;
    assign ex_load  = (EX_MemToReg == MTR_MEM);
    assign mem_load = (MEM_MemToReg == MTR_MEM);

    // PC_4 results in EX are forwardable into ID, so only ALU and load producers stall.
    always_comb begin
        n_stall = 2'd0;
        if (ex_hit && ex_load && ID_AheadBr)
            n_stall = 2'd2;
        else if ((ex_hit && ex_load) ||
                 (ID_AheadBr && ex_hit && (EX_MemToReg == MTR_ALU)) ||
                 (ID_AheadBr && mem_hit && mem_load))
            n_stall = 2'd1;
    end

    assign stall    = (state_q == ST_STALL) || (n_stall != 2'd0);
    assign irq_take = (state_q == ST_RUN) && (n_stall == 2'd0) && irq_pend_q;

    assign PC_Hold     = stall;
    assign IFID_Hold   = stall;
    assign IDEX_Bubble = stall || irq_take;
    assign IFID_Flush  = !stall && (irq_take || ID_Redirect);
    assign IRQ_Take    = irq_take;
    assign StallCnt    = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        if (state_q == ST_RUN) begin
            if (n_stall != 2'd0) begin
                left_d = (n_stall == 2'd2);
                if (n_stall == 2'd2)
                    state_d = ST_STALL;
            end
        end else begin
            left_d = left_q - 1'b1;
            if (left_d == 1'b0)
                state_d = ST_RUN;
        end
    end

    // A taken interrupt is not re-armed by the IRQ level seen in the same cycle.
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (!IRQ_En || irq_take)
            irq_pend_d = 1'b0;
        else if (IRQ)
            irq_pend_d = 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            left_q      <= 1'b0;
            irq_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            irq_pend_q  <= irq_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
